// File: rtl/vga_capture.sv
// vga_capture: locks onto an incoming VGA HS/VS timing and turns the R/G/B stream back into
// addressed pixel write strobes. Optional VCAP_CRC_EN adds a per-frame CRC-8 output (frame_crc).
module vga_capture #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned V_TOTAL  = 525,
   parameter int unsigned CLK_DIV  = 2
) (
   input  logic        sysclk,
   input  logic        rst,
   input  logic        VGA_R,
   input  logic        VGA_G,
   input  logic        VGA_B,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   output logic        pixel_valid,
   output logic [21:0] pixel_addr,
   output logic [2:0]  pixel_data,
   output logic        frame_start,
   output logic        locked,
   output logic        sync_error
`ifdef VCAP_CRC_EN
   ,
   output logic [7:0]  frame_crc
`endif
);

   localparam int unsigned LINE_CYC = H_TOTAL * CLK_DIV;
   localparam int unsigned LW = $clog2(LINE_CYC) + 1;
   localparam int unsigned FW = $clog2(V_TOTAL) + 1;
   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [LW-1:0] LINE_LAST   = LW'(LINE_CYC - 1);
   localparam logic [FW-1:0] FRAME_LINES = FW'(V_TOTAL);
   localparam logic [PW-1:0] PH_LAST     = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_MID      = PW'(CLK_DIV / 2);
   localparam logic [11:0]   X_LO        = 12'(H_BP);
   localparam logic [11:0]   X_HI        = 12'(H_BP + H_ACTIVE);
   localparam logic [11:0]   Y_LO        = 12'(V_BP);
   localparam logic [11:0]   Y_HI        = 12'(V_BP + V_ACTIVE);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [4:0]    s1_q, s2_q;
   logic          hs_prev_q, vs_prev_q;
   logic [LW-1:0] lcyc_q, lcyc_d;
   logic [FW-1:0] fcnt_q, fcnt_d, fcnt_tot;
   logic [PW-1:0] ph_q, ph_d, ph_cur;
   logic [11:0]   samp_q, samp_d, samp_cur;
   logic [11:0]   lidx_q, lidx_d;
   logic          pv_q, pv_d, fs_q, fs_d, lk_q, lk_d, se_q, se_d;
   logic [21:0]   addr_q, addr_d;
   logic [2:0]    data_q, data_d;
   logic          hs_fall, hs_rise, vs_fall, vs_rise;
   logic          sample, x_act, y_act, line_bad, frame_bad;

   // synchronised copy: {R,G,B,HS,VS}
   assign hs_fall = hs_prev_q & ~s2_q[1];
   assign hs_rise = ~hs_prev_q & s2_q[1];
   assign vs_fall = vs_prev_q & ~s2_q[0];
   assign vs_rise = ~vs_prev_q & s2_q[0];

   always_comb begin
      ph_cur    = hs_rise ? '0 : ph_q;
      sample    = (ph_cur == PH_MID);
      ph_d      = (ph_cur == PH_LAST) ? '0 : ph_cur + 1'b1;
      samp_cur  = hs_rise ? '0 : samp_q;
      samp_d    = (sample && samp_cur != '1) ? samp_cur + 12'd1 : samp_cur;
      // the HS fall coincident with a VS rise belongs to the sync line, not the back porch
      lidx_d    = vs_rise ? '0 : ((hs_fall && lidx_q != '1) ? lidx_q + 12'd1 : lidx_q);
      lcyc_d    = hs_fall ? '0 : ((lcyc_q != '1) ? lcyc_q + 1'b1 : lcyc_q);
      fcnt_tot  = fcnt_q + FW'(hs_fall);
      fcnt_d    = vs_fall ? '0 : ((fcnt_q != '1) ? fcnt_tot : fcnt_q);
      x_act     = sample && (samp_cur >= X_LO) && (samp_cur < X_HI);
      y_act     = (lidx_q >= Y_LO) && (lidx_q < Y_HI);
      line_bad  = (lcyc_q == '1) || (hs_fall && lcyc_q != LINE_LAST);
      frame_bad = (fcnt_q == '1) || (vs_fall && fcnt_tot != FRAME_LINES);
   end

   always_comb begin
      state_d = state_q;
      fs_d    = 1'b0;
      se_d    = 1'b0;
      unique case (state_q)
         SEARCH: if (vs_fall) state_d = MEASURE;
         MEASURE, LOCKED: begin
            if (line_bad || frame_bad) begin
               state_d = SEARCH;
               se_d    = 1'b1;
            end else if (vs_fall) begin
               state_d = LOCKED;
               fs_d    = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
      lk_d   = (state_d == LOCKED);
      pv_d   = (state_q == LOCKED) && (state_d == LOCKED) && x_act && y_act;
      addr_d = pv_d ? {11'(lidx_q - Y_LO), 11'(samp_cur - X_LO)} : addr_q;
      data_d = pv_d ? s2_q[4:2] : data_q;
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q   <= SEARCH;
         s1_q      <= '0;
         s2_q      <= '0;
         hs_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
         lcyc_q    <= '0;
         fcnt_q    <= '0;
         ph_q      <= '0;
         samp_q    <= '0;
         lidx_q    <= '0;
         pv_q      <= 1'b0;
         fs_q      <= 1'b0;
         lk_q      <= 1'b0;
         se_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         s1_q      <= {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS};
         s2_q      <= s1_q;
         hs_prev_q <= s2_q[1];
         vs_prev_q <= s2_q[0];
         lcyc_q    <= lcyc_d;
         fcnt_q    <= fcnt_d;
         ph_q      <= ph_d;
         samp_q    <= samp_d;
         lidx_q    <= lidx_d;
         pv_q      <= pv_d;
         fs_q      <= fs_d;
         lk_q      <= lk_d;
         se_q      <= se_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign pixel_valid = pv_q;
   assign pixel_addr  = addr_q;
   assign pixel_data  = data_q;
   assign frame_start = fs_q;
   assign locked      = lk_q;
   assign sync_error  = se_q;

`ifdef VCAP_CRC_EN
   function automatic logic [7:0] crc8_px(input logic [7:0] c, input logic [2:0] d);
      logic [7:0] r;
      logic [2:0] dd;
      r  = c;
      dd = d;
      for (int unsigned i = 0; i < 3; i++) begin
         r  = (r[7] ^ dd[2]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
         dd = {dd[1:0], 1'b0};
      end
      return r;
   endfunction

   logic [7:0] crc_acc_q, crc_acc_d, crc_q, crc_d, crc_next;

   // the accumulator is cleared on abort without touching the published value
   always_comb begin
      crc_next  = pv_d ? crc8_px(crc_acc_q, s2_q[4:2]) : crc_acc_q;
      crc_d     = fs_d ? crc_next : crc_q;
      crc_acc_d = (vs_fall || state_d != LOCKED) ? '0 : crc_next;
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         crc_acc_q <= '0;
         crc_q     <= '0;
      end else begin
         crc_acc_q <= crc_acc_d;
         crc_q     <= crc_d;
      end
   end

   assign frame_crc = crc_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a shrunken timing (14x9 pixel frame, 2 clocks per pixel).
module tb_vga_capture;
   localparam int HSW = 2, HBP = 2, HA = 8, HFP = 2, HT = HSW + HBP + HA + HFP;
   localparam int VSW = 1, VBP = 2, VA = 4, VFP = 2, VT = VSW + VBP + VA + VFP;
   localparam int D   = 2;
   localparam int LAT = 3;

   logic        sysclk = 1'b0, rst = 1'b0;
   logic        r = 1'b0, g = 1'b0, b = 1'b0, hs = 1'b1, vs = 1'b1;
   logic        pixel_valid, frame_start, locked, sync_error;
   logic [21:0] pixel_addr;
   logic [2:0]  pixel_data;
`ifdef VCAP_CRC_EN
   logic [7:0]  frame_crc;
`endif

   vga_capture #(
      .H_ACTIVE(HA), .H_BP(HBP), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_BP(VBP), .V_TOTAL(VT), .CLK_DIV(D)
   ) dut (
      .sysclk(sysclk), .rst(rst),
      .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
      .pixel_valid(pixel_valid), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
      .frame_start(frame_start), .locked(locked), .sync_error(sync_error)
`ifdef VCAP_CRC_EN
      , .frame_crc(frame_crc)
`endif
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   logic [24:0] exp_q[$];
   logic [24:0] e;
   int pv_cnt = 0, nz_cnt = 0, serr_cnt = 0, fs_cnt = 0;
   int serr_cyc = -1, fs_cyc = -1, lock_cyc = -1, unlock_cyc = -1;
   logic lk_prev = 1'b0;

   always @(negedge sysclk) begin
      if (pixel_valid) begin
         pv_cnt++;
         if (pixel_data != 3'b000) nz_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got addr=%0h data=%0b, required no strobe", pixel_addr, pixel_data);
         end else begin
            e = exp_q.pop_front();
            check("pixel", {7'b0, pixel_addr, pixel_data}, {7'b0, e});
         end
      end
      if (sync_error) begin
         serr_cnt++;
         serr_cyc = cyc;
      end
      if (frame_start) begin
         fs_cnt++;
         fs_cyc = cyc;
      end
      if (locked && !lk_prev) lock_cyc = cyc;
      if (!locked && lk_prev) unlock_cyc = cyc;
      lk_prev = locked;
   end

   function automatic logic [2:0] pat_rgb(input int pat, input int x, input int y);
      case (pat)
         1:       return 3'b111;
         2:       return (x == 5 && y == 2) ? 3'b100 : 3'b000;
         3:       return 3'((x + 3 * y + 1) % 8);
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [7:0] crc_px(input logic [7:0] c, input logic [2:0] d);
      logic [7:0] t;
      t = c;
      for (int k = 2; k >= 0; k--) begin
         if (t[7] != d[k]) t = {t[6:0], 1'b0} ^ 8'h07;
         else              t = {t[6:0], 1'b0};
      end
      return t;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pv"}, pixel_valid, 0);
      check({tag, "_addr"}, pixel_addr, 0);
      check({tag, "_data"}, pixel_data, 0);
      check({tag, "_fs"}, frame_start, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_serr"}, sync_error, 0);
   endtask

   int line_cyc[VT];
   int vsf_cyc;

   // pixels are expected only when expect_px and line < cut
   task automatic send_frame(input int nlines, input int pat, input bit expect_px,
                             input int cut, input int short_line, input int rst_line);
      for (int l = 0; l < nlines; l++) begin
         int len;
         len = (l == short_line) ? (HT - 1) * D : HT * D;
         for (int c = 0; c < len; c++) begin
            int p, x, y;
            bit act;
            logic [2:0] rgb;
            @(posedge sysclk);
            #1;
            p = c / D;
            if (c == 0) begin
               line_cyc[l] = cyc;
               if (l == 0) vsf_cyc = cyc;
            end
            x   = p - HSW - HBP;
            y   = l - VSW - VBP;
            act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
            rgb = act ? pat_rgb(pat, x, y) : 3'b000;
            hs  = (p >= HSW);
            vs  = (l >= VSW);
            {r, g, b} = rgb;
            if (act && (c % D == 0) && expect_px && l < cut)
               exp_q.push_back({11'(y), 11'(x), rgb});
            if (l == rst_line && c == 5) begin
               rst = 1'b1;
               #1;
               check_outputs_zero("midreset");
            end
            if (l == rst_line && c == 9) rst = 1'b0;
         end
      end
   endtask

   int p0, n0, s0;
`ifdef VCAP_CRC_EN
   logic [7:0] gold;
`endif

   initial begin
      #2 rst = 1'b1;
      repeat (4) @(posedge sysclk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      repeat (3) @(posedge sysclk);

      send_frame(VT, 3, 1'b0, 0, -1, -1);
      check("F1_unlocked", locked, 0);
      check("F1_no_strobes", pv_cnt, 0);

      send_frame(VT, 3, 1'b1, VT, -1, -1);
      check("lock_cycle", lock_cyc, vsf_cyc + LAT);
      check("lock_frame_start", fs_cyc, vsf_cyc + LAT);
      check("F2_strobes", pv_cnt, HA * VA);
      check("F2_no_err", serr_cnt, 0);

      p0 = pv_cnt; n0 = nz_cnt;
      send_frame(VT, 2, 1'b1, VT, -1, -1);
      check("F3_frame_start", fs_cyc, vsf_cyc + LAT);
      check("F3_strobes", pv_cnt - p0, HA * VA);
      check("F3_red_count", nz_cnt - n0, 1);

      p0 = pv_cnt;
      send_frame(VT, 3, 1'b1, 5, 4, -1);
      check("glitch_err_cycle", serr_cyc, line_cyc[5] + LAT);
      check("glitch_unlock_cycle", unlock_cyc, line_cyc[5] + LAT);
      check("glitch_err_count", serr_cnt, 1);
      check("glitch_strobes", pv_cnt - p0, 2 * HA);

      send_frame(VT, 3, 1'b0, 0, -1, -1);
      check("F5_unlocked", locked, 0);
      p0 = pv_cnt;
      send_frame(VT, 3, 1'b1, VT, -1, -1);
      check("relock_cycle", lock_cyc, vsf_cyc + LAT);
      check("F6_strobes", pv_cnt - p0, HA * VA);

      p0 = pv_cnt;
      send_frame(VT, 3, 1'b1, 4, -1, 4);
      check("reset_strobes", pv_cnt - p0, HA);
      check("reset_unlocked", locked, 0);

      s0 = serr_cnt;
      send_frame(VT - 1, 3, 1'b0, 0, -1, -1);
      send_frame(VT, 3, 1'b0, 0, -1, -1);
      check("short_frame_err_cycle", serr_cyc, vsf_cyc + LAT);
      check("short_frame_err_count", serr_cnt - s0, 1);
      check("short_frame_unlocked", locked, 0);
      send_frame(VT, 3, 1'b0, 0, -1, -1);
      check("F10_unlocked", locked, 0);
      p0 = pv_cnt;
      send_frame(VT, 3, 1'b1, VT, -1, -1);
      check("F11_lock_cycle", lock_cyc, vsf_cyc + LAT);
      check("F11_strobes", pv_cnt - p0, HA * VA);

`ifdef VCAP_CRC_EN
      send_frame(VT, 1, 1'b1, VT, -1, -1);
      send_frame(VT, 0, 1'b1, VT, -1, -1);
      gold = 8'h00;
      for (int i = 0; i < HA * VA; i++) gold = crc_px(gold, 3'b111);
      check("crc_white", frame_crc, gold);
      send_frame(VT, 3, 1'b1, VT, -1, -1);
      check("crc_black", frame_crc, 8'h00);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
